// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: default constants shared by the switch debouncer files
package sw_debounce_pkg;
  localparam int SW_WIDTH = 18;
  localparam int SW_TICK_DIV = 50000;
  localparam int SW_STABLE_TICKS = 4;
endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw switch inputs, debounced outputs, change pulses and tick strobe
interface sw_debounce_if import sw_debounce_pkg::*; #(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] changed;
  logic tick;
  modport master (output sw_in, input sw_out, input changed, input tick);
  modport slave (input sw_in, output sw_out, output changed, output tick);
endinterface

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan: one switch channel with synchronizer, stability counter and output flop
module sw_debounce_chan import sw_debounce_pkg::*; #(
  parameter int STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic sw_i,
  output logic sw_o,
  output logic changed_o
);
  localparam int CW = $clog2(STABLE_TICKS);
  logic s1_q, s2_q, out_q, chg_q, out_d, chg_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  // count consecutive disagreeing ticks and accept the new level on the last one
  always_comb begin
    accept = tick_i && (s2_q != out_q) && (cnt_q == CW'(STABLE_TICKS - 1));
    cnt_d = !tick_i ? cnt_q : (s2_q == out_q || accept) ? '0 : cnt_q + CW'(1);
    out_d = accept ? s2_q : out_q;
    chg_d = accept;
  end
  // synchronizer, counter and debounced level registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_BIT;
      s2_q <= RESET_BIT;
      out_q <= RESET_BIT;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      out_q <= out_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end
  assign sw_o = out_q;
  assign changed_o = chg_q;
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: multi-channel switch debouncer sampled on a shared prescaler tick
module sw_debounce import sw_debounce_pkg::*; #(
  parameter int WIDTH = SW_WIDTH,
  parameter int TICK_DIV = SW_TICK_DIV,
  parameter int STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  sw_debounce_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] sw_out, changed;
  logic tick;
  assign tick = pre_q == LAST;
  // prescaler wraps after the tick cycle
  always_comb pre_d = tick ? '0 : pre_q + PW'(1);
  // prescaler register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_BIT(RESET_VALUE[i])
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .tick_i(tick),
      .sw_i(bus.sw_in[i]),
      .sw_o(sw_out[i]),
      .changed_o(changed[i])
    );
  end
  assign bus.sw_out = sw_out;
  assign bus.changed = changed;
  assign bus.tick = tick;
endmodule
